sha3_theta_apply: RTL

SHA3_THETA_APPLY -- requirements
Module: sha3_theta_apply

---
 rtl/sha3_pkg.sv | 18 +
 rtl/sha3_lane_delay.sv | 49 ++++
 rtl/sha3_theta_apply.sv | 91 +++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared lane/row/state types and the default theta-element latency for the SHA-3 theta path.
package sha3_pkg;

    typedef logic [63:0] lane_t;
    typedef lane_t [4:0] row_t;
    typedef row_t  [4:0] state_t;

    localparam int unsigned SHA3_THETA_ELT_LATENCY = 3;

    function automatic row_t row_xor(input row_t row, input row_t elt);
        row_t res;
        for (int x = 0; x < 5; x++) begin
            res[x] = row[x] ^ elt[x];
        end
        return res;
    endfunction

endpackage

// File: rtl/sha3_lane_delay.sv
// State-plus-valid shift register; aligns a captured state with its late-arriving theta elements.
module sha3_lane_delay
    import sha3_pkg::*;
#(
    parameter int unsigned Depth = SHA3_THETA_ELT_LATENCY
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   valid_i,
    input  state_t data_i,
    output state_t data_o,
    output logic   valid_o,
    output logic   busy_o
);

    state_t             data_q [Depth];
    logic   [Depth-1:0] valid_q;
    logic   [Depth-1:0] valid_d;

    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = valid_i;
        for (int i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    // A capture coinciding with rst is dropped because the flush wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data is never reset; its content is meaningless while the matching valid bit is low.
    always_ff @(posedge clk_i) begin
        data_q[0] <= data_i;
        for (int i = 1; i < Depth; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign data_o  = data_q[Depth-1];
    assign valid_o = valid_q[Depth-1];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/sha3_theta_apply.sv
// Theta apply: delays each sampled state until its theta elements arrive, then XORs per column.
// Optional SHA3_THETA_OUTREG_EN registers the result and its valid bit (one extra cycle).
module sha3_theta_apply
    import sha3_pkg::*;
#(
    parameter int unsigned ELT_LATENCY = SHA3_THETA_ELT_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  row_t isa,
    input  row_t isb,
    input  row_t isc,
    input  row_t isd,
    input  row_t ise,
    input  logic sample,
    input  row_t ielt,
    output row_t osa,
    output row_t osb,
    output row_t osc,
    output row_t osd,
    output row_t ose,
    output logic ovalid,
    output logic busy
);

    state_t in_state;
    state_t dl_data;
    logic   dl_valid;
    logic   dl_busy;
    state_t res_d;
    state_t out_state;

    always_comb begin
        in_state[0] = isa;
        in_state[1] = isb;
        in_state[2] = isc;
        in_state[3] = isd;
        in_state[4] = ise;
    end

    sha3_lane_delay #(
        .Depth(ELT_LATENCY)
    ) u_delay (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(sample),
        .data_i (in_state),
        .data_o (dl_data),
        .valid_o(dl_valid),
        .busy_o (dl_busy)
    );

    always_comb begin
        res_d = '0;
        for (int r = 0; r < 5; r++) begin
            res_d[r] = row_xor(dl_data[r], ielt);
        end
    end

`ifdef SHA3_THETA_OUTREG_EN
    state_t res_q;
    logic   valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= dl_valid;
        end
    end

    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign out_state = res_q;
    assign ovalid    = valid_q;
    assign busy      = dl_busy | valid_q;
`else
    assign out_state = res_d;
    assign ovalid    = dl_valid;
    assign busy      = dl_busy;
`endif

    assign osa = out_state[0];
    assign osb = out_state[1];
    assign osc = out_state[2];
    assign osd = out_state[3];
    assign ose = out_state[4];

endmodule
